// File: rtl/button_conditioner.sv
// Conditions raw asynchronous buttons into debounced CLK-domain levels plus rise/fall pulses.
// Optional long-press pulse per channel is built when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.
module button_conditioner #(
    parameter int   WIDTH           = 8,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 12000,
    parameter logic IDLE_LEVEL      = 1'b0,
    parameter int   LONG_CYCLES     = 12000000
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall,
    output logic             any_rise,
    output logic [WIDTH-1:0] btn_long
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_conditioner: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
        end
        if (LONG_CYCLES < 1) begin : g_bad_long
            $error("button_conditioner: LONG_CYCLES must be >= 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              any_rise_q, any_rise_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = sync_q;
        sync_d[0] = btn_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // The level only flips on the edge where the counter already sits at its last value,
    // so the counter itself never needs to hold DEBOUNCE_CYCLES.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        any_rise_d = |rise_d;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{IDLE_VEC}};
            level_q    <= IDLE_VEC;
            cnt_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_rise_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= any_rise_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;
    assign any_rise  = any_rise_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] HOLD_ONE  = LW'(1);

    logic [WIDTH-1:0][LW-1:0] hold_q, hold_d;
    logic [WIDTH-1:0]         long_q, long_d;

    // Parking at LONG_CYCLES (one past the pulse value) guarantees a single pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] == HOLD_LAST) begin
                hold_d[i] = HOLD_SAT;
                long_d[i] = 1'b1;
            end else if (hold_q[i] != HOLD_SAT) begin
                hold_d[i] = hold_q[i] + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=8.
module tb_button_conditioner;

    logic       CLK = 1'b0;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic       any_rise;
    logic [1:0] btn_long;

    int pass_cnt  = 0;
    int total_cnt = 0;

    button_conditioner #(
        .WIDTH           (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .IDLE_LEVEL      (1'b0),
        .LONG_CYCLES     (8)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .any_rise  (any_rise),
        .btn_long  (btn_long)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst    = 1'b1;
        btn_in = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick();
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise, btn_long} !== 9'b0)
                $display("FAIL reset_hold cycle %0d: got %b expected %b", c,
                         {btn_level, btn_rise, btn_fall, any_rise, btn_long}, 9'b0);
            else
                pass_cnt++;
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp = {(e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, (e == 6)};
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== exp)
                $display("FAIL reset_release edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, exp);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_clean_press();
        logic [6:0] exp;
        do_reset();
        btn_in = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 6)};
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== exp)
                $display("FAIL press edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, exp);
            else
                pass_cnt++;
        end
        btn_in = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e >= 6) ? 2'b00 : 2'b01, 2'b00, (e == 6) ? 2'b01 : 2'b00, 1'b0};
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== exp)
                $display("FAIL release edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, exp);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        logic [1:0] vals [5];
        int         durs [5];
        vals = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        durs = '{3, 1, 3, 1, 5};
        do_reset();
        for (int p = 0; p < 5; p++) begin
            btn_in = vals[p];
            for (int c = 0; c < durs[p]; c++) begin
                tick();
                total_cnt++;
                if ({btn_level, btn_rise, btn_fall, any_rise} !== 7'b0)
                    $display("FAIL bounce phase %0d cycle %0d: got %b expected %b", p, c,
                             {btn_level, btn_rise, btn_fall, any_rise}, 7'b0);
                else
                    pass_cnt++;
            end
        end
        tick();
        total_cnt++;
        if ({btn_level, btn_rise, btn_fall, any_rise} !== 7'b01_01_00_1)
            $display("FAIL bounce_settle_rise: got %b expected %b",
                     {btn_level, btn_rise, btn_fall, any_rise}, 7'b01_01_00_1);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({btn_level, btn_rise, btn_fall, any_rise} !== 7'b01_00_00_0)
            $display("FAIL bounce_after_rise: got %b expected %b",
                     {btn_level, btn_rise, btn_fall, any_rise}, 7'b01_00_00_0);
        else
            pass_cnt++;
    endtask

    task automatic test_independence();
        logic [6:0] exp;
        do_reset();
        btn_in = 2'b01;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp = {(e >= 8) ? 1'b1 : 1'b0, (e >= 6) ? 1'b1 : 1'b0,
                   (e == 8) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0,
                   2'b00, (e == 6 || e == 8)};
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== exp)
                $display("FAIL independence edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, exp);
            else
                pass_cnt++;
            if (e == 2) btn_in = 2'b11;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [6:0] exp;
        do_reset();
        btn_in = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== 7'b0)
                $display("FAIL midcount_pre edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, 7'b0);
            else
                pass_cnt++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== 7'b0)
                $display("FAIL midcount_in_reset cycle %0d: got %b expected %b", c,
                         {btn_level, btn_rise, btn_fall, any_rise}, 7'b0);
            else
                pass_cnt++;
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 6)};
            total_cnt++;
            if ({btn_level, btn_rise, btn_fall, any_rise} !== exp)
                $display("FAIL midcount_restart edge %0d: got %b expected %b", e,
                         {btn_level, btn_rise, btn_fall, any_rise}, exp);
            else
                pass_cnt++;
        end
    endtask

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    task automatic test_long_press();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            btn_in = 2'b01;
            repeat (6) tick();
            total_cnt++;
            if (btn_level !== 2'b01)
                $display("FAIL long_setup_level press %0d: got %b expected %b", r, btn_level, 2'b01);
            else
                pass_cnt++;
            for (int k = 1; k <= 12; k++) begin
                tick();
                total_cnt++;
                if (btn_long !== ((k == 8) ? 2'b01 : 2'b00))
                    $display("FAIL long_pulse press %0d edge %0d: got %b expected %b", r, k,
                             btn_long, (k == 8) ? 2'b01 : 2'b00);
                else
                    pass_cnt++;
            end
            btn_in = 2'b00;
            for (int c = 0; c < 8; c++) begin
                tick();
                total_cnt++;
                if (btn_long !== 2'b00)
                    $display("FAIL long_release press %0d cycle %0d: got %b expected %b", r, c,
                             btn_long, 2'b00);
                else
                    pass_cnt++;
            end
        end
    endtask
`else
    task automatic test_long_tied_off();
        do_reset();
        btn_in = 2'b11;
        for (int c = 0; c < 30; c++) begin
            if (c == 20) btn_in = 2'b00;
            tick();
            total_cnt++;
            if (btn_long !== 2'b00)
                $display("FAIL long_tied_off cycle %0d: got %b expected %b", c, btn_long, 2'b00);
            else
                pass_cnt++;
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        btn_in = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_independence();
        test_reset_mid_count();
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        test_long_press();
`else
        test_long_tied_off();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
